// File: rtl/fir_pkg.sv
// Shared constants and FSM state type for the 61-tap serial FIR.
package fir_pkg;
  localparam int NTAPS      = 61;
  localparam int DATA_W     = 8;
  localparam int COEFF_W    = 10;
  localparam int ACC_W      = 24;
  localparam int Y_W        = 18;
  localparam int RING_DEPTH = 64;
  localparam int RING_AW    = 6;
  localparam int PROD_W     = DATA_W + COEFF_W;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    MAC   = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/fir61_serial_sample_ring.sv
// sample_ring: 64-entry sample history, synchronous write, asynchronous read.
module sample_ring
  import fir_pkg::*;
(
  input  logic               clock,
  input  logic               we,
  input  logic [RING_AW-1:0] waddr,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [RING_AW-1:0] raddr,
  output logic [DATA_W-1:0]  rdata
);
  logic [DATA_W-1:0] mem [RING_DEPTH];

  // Contents deliberately have no reset; the CLEAR sweep zeroes them.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fir61_serial.sv
// fir61_serial: 61-tap FIR, one MAC per cycle against an external coefficient ROM.
// Build option FIR_SAT_EN: saturate y to the Y_W signed range instead of wrapping.
//
// state | meaning
// CLEAR | zero ring entries 0..63, one per cycle
// IDLE  | wait for ready, store sample, advance offset
// MAC   | tap i = 0..60, acc += coeff[i] * newest-minus-i sample
// DONE  | register y from acc, pulse y_valid next cycle
module fir61_serial
  import fir_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               ready,
  input  logic [DATA_W-1:0]  x,
  output logic [5:0]         index,
  input  logic [COEFF_W-1:0] coeff,
  output logic [Y_W-1:0]     y,
  output logic               y_valid,
  output logic               busy,
  output logic               overrun
);
  state_t state, state_nxt;

  logic [RING_AW-1:0]      clr_cnt, offset, tap;
  logic [RING_AW-1:0]      wr_addr, rd_addr;
  logic                    wr_en;
  logic [DATA_W-1:0]       wr_data, rd_data;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;
  logic [Y_W-1:0]          y_nxt;
  logic                    last_tap;

  assign last_tap = (tap == RING_AW'(NTAPS - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= CLEAR;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_cnt == RING_AW'(RING_DEPTH - 1)) state_nxt = IDLE;
      IDLE:    if (ready) state_nxt = MAC;
      MAC:     if (last_tap) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    index   = '0;
    wr_en   = 1'b0;
    wr_addr = clr_cnt;
    wr_data = '0;
    case (state)
      CLEAR: wr_en = 1'b1;
      IDLE: begin
        if (ready) begin
          wr_en   = 1'b1;
          wr_addr = offset;
          wr_data = x;
        end
      end
      MAC:     index = tap;
      default: ;
    endcase
  end

  // offset already points past the newest sample while in MAC.
  assign rd_addr = offset - RING_AW'(1) - tap;
  assign prod    = PROD_W'($signed(rd_data)) * PROD_W'($signed(coeff));

  sample_ring u_ring (
    .clock (clock),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((1 << (Y_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

  always_comb begin
    if (acc > Y_MAX)      y_nxt = Y_W'(Y_MAX);
    else if (acc < Y_MIN) y_nxt = Y_W'(Y_MIN);
    else                  y_nxt = Y_W'(acc);
  end
`else
  assign y_nxt = Y_W'(acc);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clr_cnt <= '0;
      offset  <= '0;
      tap     <= '0;
      acc     <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      overrun <= 1'b0;
      case (state)
        CLEAR: clr_cnt <= clr_cnt + RING_AW'(1);
        IDLE: begin
          if (ready) begin
            offset <= offset + RING_AW'(1);
            tap    <= '0;
            acc    <= '0;
          end
        end
        MAC: begin
          acc     <= acc + ACC_W'(prod);
          tap     <= tap + RING_AW'(1);
          overrun <= ready;
        end
        DONE: begin
          y       <= y_nxt;
          y_valid <= 1'b1;
          overrun <= ready;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fir61_serial.sv
// Self-checking bench for fir61_serial: ROM model, golden FIR scoreboard, directed steps.
module tb_fir61_serial;
  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        ready   = 1'b0;
  logic [7:0]  x       = 8'd0;
  logic [5:0]  index;
  logic [9:0]  coeff;
  logic [17:0] y;
  logic        y_valid;
  logic        busy;
  logic        overrun;

  fir61_serial dut (
    .clock   (clock),
    .reset_n (reset_n),
    .ready   (ready),
    .x       (x),
    .index   (index),
    .coeff   (coeff),
    .y       (y),
    .y_valid (y_valid),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int checks = 0;
  int errors = 0;
  int mode   = 0;
  int ctab[64];
  int ov_count = 0;
  int yv_count = 0;

  typedef struct {
    longint y;
    int     cyc;
  } exp_t;
  exp_t q[$];
  int   hist[$];

  always_comb begin
    case (mode)
      0:       coeff = 10'(int'(index) + 1);
      1:       coeff = 10'd511;
      default: coeff = 10'(ctab[index]);
    endcase
  end

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int rom(input int k);
    case (mode)
      0:       return k + 1;
      1:       return 511;
      default: return ctab[k];
    endcase
  endfunction

  function automatic longint model_y();
    longint acc = 0;
    for (int k = 0; k < hist.size() && k < 61; k++)
      acc += longint'(rom(k)) * longint'(hist[k]);
`ifdef FIR_SAT_EN
    if (acc > 131071) acc = 131071;
    if (acc < -131072) acc = -131072;
`else
    acc = acc & 64'h3FFFF;
    if (acc >= 131072) acc = acc - 262144;
`endif
    return acc;
  endfunction

  always @(negedge clock) begin
    if (reset_n) begin
      if (overrun) ov_count++;
      if (!busy) check("index_idle", index, 0);
      if (y_valid) begin
        exp_t e;
        yv_count++;
        check("y_valid_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("y", $signed(y), e.y);
          check("latency", cyc, e.cyc);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send(input int xv, input int wait_after);
    exp_t e;
    ready = 1'b1;
    x     = 8'(xv);
    hist.push_front(xv);
    if (hist.size() > 64) void'(hist.pop_back());
    e.y   = model_y();
    e.cyc = cyc + 63;
    q.push_back(e);
    tick(1);
    ready = 1'b0;
    tick(wait_after);
  endtask

  task automatic drop(input int xv);
    ready = 1'b1;
    x     = 8'(xv);
    tick(1);
    ready = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      tick(1);
      n++;
    end
    tick(1);
    check({tag, "_drain"}, q.size(), 0);
  endtask

  task automatic clear_phase(input string tag);
    int n = 0;
    int ov0 = ov_count;
    int yv0 = yv_count;
    reset_n = 1'b1;
    while (busy && n < 100) begin
      n++;
      ready = (n == 10 || n == 40);
      x     = 8'd55;
      tick(1);
    end
    ready = 1'b0;
    check({tag, "_busy_cycles"}, n, 64);
    #1;
    check({tag, "_no_overrun"}, ov_count - ov0, 0);
    check({tag, "_no_y_valid"}, yv_count - yv0, 0);
    check({tag, "_y_zero"}, $signed(y), 0);
    tick(1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) ctab[i] = int'($urandom_range(0, 1023)) - 512;

    tick(3);
    check("rst_busy", busy, 1);
    check("rst_index", index, 0);
    check("rst_y", $signed(y), 0);
    check("rst_y_valid", y_valid, 0);
    check("rst_overrun", overrun, 0);
    clear_phase("clr1");

    mode = 0;
    send(1, 62);
    check("impulse_first", $signed(y), 1);
    for (int j = 1; j < 62; j++) send(0, 62);
    drain("impulse");
    check("impulse_tail", $signed(y), 0);

    send(5, 9);
    drop(99);
    check("overrun_mac", overrun, 1);
    tick(1);
    check("overrun_single", overrun, 0);
    tick(50);
    drop(77);
    check("overrun_done", overrun, 1);
    tick(1);
    send(-3, 62);
    drain("overrun");

    mode = 1;
    for (int j = 0; j < 61; j++) send(127, 62);
    drain("dc_pos");
`ifdef FIR_SAT_EN
    check("dc_pos_y", $signed(y), 131071);
`else
    check("dc_pos_y", $signed(y), 26557);
`endif
    for (int j = 0; j < 61; j++) send(-128, 62);
    drain("dc_neg");
`ifdef FIR_SAT_EN
    check("dc_neg_y", $signed(y), -131072);
`else
    check("dc_neg_y", $signed(y), -57728);
`endif

    mode = 2;
    for (int j = 0; j < 200; j++)
      send(int'($urandom_range(0, 255)) - 128, 62 + int'($urandom_range(0, 2)));
    drain("random");

    send(33, 29);
    reset_n = 1'b0;
    q.delete();
    hist.delete();
    #1;
    check("midrst_y", $signed(y), 0);
    check("midrst_busy", busy, 1);
    check("midrst_index", index, 0);
    check("midrst_y_valid", y_valid, 0);
    check("midrst_overrun", overrun, 0);
    tick(3);
    clear_phase("clr2");
    send(-77, 62);
    drain("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fir61_serial.md
FIR61_SERIAL -- requirements
Module: fir61_serial

Interface
REQ-001 Parameters: NTAPS, 61, tap count; DATA_W, 8, sample width; COEFF_W, 10, coefficient width; ACC_W, 24, accumulator width; Y_W, 18, output width.
REQ-002 clock  in  1  system clock; all state on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 ready  in  1  one-cycle strobe; new sample present on x.
REQ-005 x  in  DATA_W  signed input sample.
REQ-006 index  out  6  address to the external coefficient ROM.
REQ-007 coeff  in  COEFF_W  signed ROM data; combinational from index, valid the same cycle.
REQ-008 y  out  Y_W  signed filtered output, held between updates.
REQ-009 y_valid  out  1  one-cycle pulse when y updates.
REQ-010 busy  out  1  high in CLEAR, MAC and DONE.
REQ-011 overrun  out  1  one-cycle pulse when a ready strobe is dropped.

Function
REQ-012 The FSM SHALL have four states: CLEAR, IDLE, MAC, DONE.
REQ-013 CLEAR: write zero to ring entries 0..63, one per cycle, over 64 cycles, then go to IDLE.
REQ-014 IDLE with ready=1 at cycle T: write x at offset, offset <= offset+1 (6-bit wrap 63->0), tap counter i <= 0, go to MAC.
REQ-015 MAC cycles T+1..T+61, with i = 0..60: index = i; acc += coeff * ring[(offset-1-i) mod 64], using the post-increment offset, so i=0 multiplies the newest sample.
REQ-016 Arithmetic: product is DATA_W+COEFF_W = 18 bits signed; it is sign-extended to ACC_W; acc is cleared on entry to MAC.
REQ-017 After i=60 the FSM SHALL go to DONE (cycle T+62); DONE registers y from acc and returns to IDLE.
REQ-018 y_valid SHALL be high in cycle T+63 only; busy SHALL be high in T+1..T+62.
REQ-019 A ready strobe in cycle T+63 SHALL be accepted, so back-to-back samples run every 63 cycles.
REQ-020 ready=1 in MAC or DONE SHALL be dropped, with no buffer write and no offset change; overrun pulses the following cycle.
REQ-021 ready=1 in CLEAR SHALL be dropped silently, with no overrun.
REQ-022 index SHALL be 0 in every state other than MAC.

Reset
REQ-023 reset_n low, including mid-MAC, SHALL force: state=CLEAR, clear counter=0, offset=0, i=0, acc=0, y=0, y_valid=0, overrun=0, index=0; busy SHALL be 1 while reset is held.
REQ-024 Ring contents are not reset asynchronously; the CLEAR sweep zeroes them after release.

Configuration
REQ-025 With FIR_SAT_EN defined, y SHALL be acc saturated to the Y_W signed range [-131072, 131071].
REQ-026 Without FIR_SAT_EN, y SHALL be acc[Y_W-1:0], wrapping.

Structure
REQ-027 Package fir_pkg SHALL hold NTAPS, DATA_W, COEFF_W, ACC_W, Y_W, RING_DEPTH=64 and the state enum.
REQ-028 Sub-module sample_ring: 64 x DATA_W storage with synchronous write and asynchronous read; one write port and one read port.

Verification
REQ-029 Reset release: busy high 64 cycles, y=0, y_valid=0, and ready pulses during CLEAR produce no output and no overrun.
REQ-030 Impulse with ROM model coeff=index+1: x=1 then 61 zeros -> y = 1, 2, ..., 61 on successive y_valid pulses, then 0; each y_valid pulse 63 cycles after its ready.
REQ-031 DC overflow with x=127 and coeff=511 for all taps, once the buffer is full -> acc=3958717; with FIR_SAT_EN y=131071, without it y=26557.
REQ-032 Negative saturation with x=-128, coeff=511, FIR_SAT_EN -> acc=-3989888, y=-131072.
REQ-033 ready at T and again at T+10 -> overrun pulse at T+11; the result at T+63 matches the single-sample golden model.
REQ-034 200 random samples against a bit-accurate golden FIR, including offset wrap, plus reset_n asserted mid-MAC -> y=0 and CLEAR re-entered with no spurious y_valid.
